// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants for the VGA 640x480@60 scan-out path.
//               Holds the default horizontal/vertical timing, the derived
//               sync window and total constants, the logical framebuffer
//               geometry, and the framebuffer address width that is also
//               used when the RAM is instantiated.
// Ports       : none (package)
// Options     : none
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  // Horizontal timing, in pixel clocks.
  localparam int VGA_H_ACTIVE     = 640;
  localparam int VGA_H_FP         = 16;
  localparam int VGA_H_SYNC       = 96;
  localparam int VGA_H_BP         = 48;
  localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;

  // Vertical timing, in lines.
  localparam int VGA_V_ACTIVE     = 480;
  localparam int VGA_V_FP         = 10;
  localparam int VGA_V_SYNC       = 2;
  localparam int VGA_V_BP         = 33;
  localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  // Logical framebuffer: 160x120 words, each shown as a 4x4 block.
  localparam int VGA_SCALE_SHIFT  = 2;
  localparam int VGA_FB_WIDTH     = 160;

  // Framebuffer port widths; the RAM instance uses the same values.
  localparam int VGA_AWIDTH       = 15;
  localparam int VGA_PIX_WIDTH    = 3;

endpackage : vga_pkg

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : Free-running VGA raster counters plus the stage-0 decode of
//               the visible window, active-low sync levels and vertical blank.
//               Also used by the upstream pixel writer for its blanking logic.
// Ports       : clk      in   pixel clock
//               rst      in   synchronous, active-high reset
//               hcount   out  horizontal position 0..H_TOTAL-1
//               vcount   out  vertical position 0..V_TOTAL-1
//               active   out  inside the visible window
//               hsync_n  out  horizontal sync, active-low, undelayed
//               vsync_n  out  vertical sync, active-low, undelayed
//               vblank   out  vcount >= V_ACTIVE (held low during reset)
// Options     : none
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       active,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       vblank
);

  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Line and frame wrap share the same edge at the last pixel of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 10'd1;
    end
  end

  assign active  = (hcount < H_VIS) && (vcount < V_VIS);
  assign hsync_n = !((hcount >= HS_START) && (hcount <= HS_END));
  assign vsync_n = !((vcount >= VS_START) && (vcount <= VS_END));

  // Gated so the writer never sees a stale blank flag from before reset.
  assign vblank  = !rst && (vcount >= V_VIS);

endmodule : vga_timing_gen

`default_nettype wire

// File: rtl/vga_scanout.sv
// ============================================================================
// Module      : vga_scanout
// Description : VGA 640x480@60 scan-out. Drives the framebuffer read address
//               for a 160x120 image replicated 4x in each direction, takes
//               the RAM's registered read data one cycle later, and emits
//               RGB/HSync/VSync two cycles after the counter stage.
// Ports       : Clock_25     in   pixel clock (shared with the RAM read port)
//               Reset        in   synchronous, active-high
//               TestPattern  in   colour-bar select (optional build only)
//               RAddress     out  framebuffer read address, combinational
//               DataIn       in   RAM read data, valid one cycle after RAddress
//               RGB          out  registered pixel colour {R,G,B}
//               HSync        out  registered, active-low
//               VSync        out  registered, active-low
//               VBlank       out  vertical blank level, undelayed
// Options     : VGA_SCANOUT_TEST_PATTERN_EN adds TestPattern and an
//               eight-bar colour generator that replaces DataIn.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter int SCALE_SHIFT = VGA_SCALE_SHIFT,
  parameter int FB_WIDTH    = VGA_FB_WIDTH,
  parameter int AWidth      = VGA_AWIDTH,
  parameter int Width       = VGA_PIX_WIDTH
) (
  input  logic              Clock_25,
  input  logic              Reset,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  input  logic              TestPattern,
`endif
  output logic [AWidth-1:0] RAddress,
  input  logic [Width-1:0]  DataIn,
  output logic [Width-1:0]  RGB,
  output logic              HSync,
  output logic              VSync,
  output logic              VBlank
);

  localparam logic [9:0] COL_MAX = 10'(FB_WIDTH - 1);
  localparam logic [9:0] ROW_MAX = 10'((V_ACTIVE >> SCALE_SHIFT) - 1);

  logic [9:0] hcount, vcount;
  logic       active0, hs0_n, vs0_n;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk     (Clock_25),
    .rst     (Reset),
    .hcount  (hcount),
    .vcount  (vcount),
    .active  (active0),
    .hsync_n (hs0_n),
    .vsync_n (vs0_n),
    .vblank  (VBlank)
  );

  // ---------------------------------------------------------------- address
  // Clamping keeps the address inside the image during blanking, so the RAM
  // is never read out of range.
  logic [9:0]        col_raw, row_raw, col, row;
  logic [AWidth-1:0] row_base;

  assign col_raw = hcount >> SCALE_SHIFT;
  assign row_raw = vcount >> SCALE_SHIFT;
  assign col     = (col_raw > COL_MAX) ? COL_MAX : col_raw;
  assign row     = (row_raw > ROW_MAX) ? ROW_MAX : row_raw;

  // row * FB_WIDTH as a sum of shifted copies of row, one per set bit of the
  // constant; for 160 this is (row << 7) + (row << 5).
  always_comb begin
    row_base = '0;
    for (int i = 0; i < AWidth; i++) begin
      if (FB_WIDTH[i]) begin
        row_base = row_base + (AWidth'(row) << i);
      end
    end
  end

  assign RAddress = row_base + AWidth'(col);

  // ---------------------------------------------------------------- stage 1
  // Registered on the same edge the RAM captures RAddress, so DataIn lines
  // up with these values during the following cycle.
  logic active1, hs1_n, vs1_n;

  always_ff @(posedge Clock_25) begin
    if (Reset) begin
      active1 <= 1'b0;
      hs1_n   <= 1'b1;
      vs1_n   <= 1'b1;
    end else begin
      active1 <= active0;
      hs1_n   <= hs0_n;
      vs1_n   <= vs0_n;
    end
  end

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  // bar1 is the bar index of the stage-1 pixel (hcount one cycle ago,
  // divided by H_ACTIVE/8). bar_px counts pixels within the current bar.
  localparam logic [9:0] BAR_LAST = 10'(H_ACTIVE / 8 - 1);

  logic [9:0] bar_px;
  logic [2:0] bar1;

  always_ff @(posedge Clock_25) begin
    if (Reset || hcount == '0) begin
      bar_px <= '0;
      bar1   <= '0;
    end else if (bar_px == BAR_LAST) begin
      bar_px <= '0;
      bar1   <= bar1 + 3'd1;
    end else begin
      bar_px <= bar_px + 10'd1;
    end
  end
`endif

  // ---------------------------------------------------------------- stage 2
  logic [Width-1:0] pix;

  always_comb begin
    pix = DataIn;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    if (TestPattern) begin
      pix = Width'(bar1);
    end
`endif
  end

  always_ff @(posedge Clock_25) begin
    if (Reset) begin
      RGB   <= '0;
      HSync <= 1'b1;
      VSync <= 1'b1;
    end else begin
      RGB   <= active1 ? pix : '0;
      HSync <= hs1_n;
      VSync <= vs1_n;
    end
  end

endmodule : vga_scanout

`default_nettype wire

// File: tb/tb_vga_scanout.sv
// ============================================================================
// Module      : tb_vga_scanout
// Description : Self-checking bench for vga_scanout. Runs a full-size
//               640x480 instance (a) and a reduced-timing instance (b) in
//               lockstep, each fed by its own behavioural RAM, and compares
//               every cycle against a raster model built from cycle counts.
// Ports       : none
// Options     : VGA_SCANOUT_TEST_PATTERN_EN enables colour-bar checks.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_scanout;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, fbw;
  } cfg_t;

  logic        clk;
  logic        rst_a, rst_b, frc_a, frc_b, tp_a, tp_b;
  logic [14:0] addr_a, addr_b;
  logic [2:0]  din_a, din_b, rgb_a, rgb_b;
  logic        hs_a, vs_a, vb_a, hs_b, vs_b, vb_b;
  logic [2:0]  mem [0:19199];
  cfg_t        cfg [2];

  int   passes, total, n_a, n_b;
  bit   fa_last, fb_last, a_first_seen;
  int   a_fall, b_hfall, b_vfall, b_vbrise;
  logic p_hs_a, p_hs_b, p_vs_b, p_vb_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_scanout dut_a (
    .Clock_25    (clk),
    .Reset       (rst_a),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    .TestPattern (tp_a),
`endif
    .RAddress    (addr_a),
    .DataIn      (din_a),
    .RGB         (rgb_a),
    .HSync       (hs_a),
    .VSync       (vs_a),
    .VBlank      (vb_a)
  );

  vga_scanout #(
    .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_ACTIVE (48), .V_FP (2), .V_SYNC (2), .V_BP (3),
    .FB_WIDTH (16)
  ) dut_b (
    .Clock_25    (clk),
    .Reset       (rst_b),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    .TestPattern (tp_b),
`endif
    .RAddress    (addr_b),
    .DataIn      (din_b),
    .RGB         (rgb_b),
    .HSync       (hs_b),
    .VSync       (vs_b),
    .VBlank      (vb_b)
  );

  // Behavioural RAMs: one-cycle registered read, optionally forced to white.
  always @(posedge clk) begin
    din_a <= frc_a ? 3'b111 : ((addr_a < 15'd19200) ? mem[addr_a] : 3'b000);
    din_b <= frc_b ? 3'b111 : ((addr_b < 15'd19200) ? mem[addr_b] : 3'b000);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // n = clock edges since reset release (0 while in reset). The counters sit
  // at raster position n; the pins show raster position n-2.
  task automatic check_dut(input int c, input int n, input bit frc, input bit tp,
                           input logic [14:0] addr, input logic [2:0] rgb,
                           input logic hs, input logic vs, input logic vb);
    int ht, vt, h, v, row, col, p;
    logic [2:0] e_rgb;
    logic e_hs, e_vs;
    string nm;
    nm  = (c == 0) ? "a" : "b";
    ht  = cfg[c].ha + cfg[c].hfp + cfg[c].hsw + cfg[c].hbp;
    vt  = cfg[c].va + cfg[c].vfp + cfg[c].vsw + cfg[c].vbp;
    h   = n % ht;
    v   = (n / ht) % vt;
    row = v / 4;
    if (row > cfg[c].va / 4 - 1) row = cfg[c].va / 4 - 1;
    col = h / 4;
    if (col > cfg[c].fbw - 1) col = cfg[c].fbw - 1;
    chk({nm, "_raddr"}, 32'(addr), row * cfg[c].fbw + col);
    chk({nm, "_vblank"}, 32'(vb), (v >= cfg[c].va) ? 1 : 0);
    e_rgb = 3'b000;
    e_hs  = 1'b1;
    e_vs  = 1'b1;
    p = n - 2;
    if (p >= 0) begin
      h = p % ht;
      v = (p / ht) % vt;
      e_hs = !(h >= cfg[c].ha + cfg[c].hfp && h < cfg[c].ha + cfg[c].hfp + cfg[c].hsw);
      e_vs = !(v >= cfg[c].va + cfg[c].vfp && v < cfg[c].va + cfg[c].vfp + cfg[c].vsw);
      if (h < cfg[c].ha && v < cfg[c].va) begin
        if (tp)       e_rgb = 3'(h / (cfg[c].ha / 8));
        else if (frc) e_rgb = 3'b111;
        else          e_rgb = mem[(v / 4) * cfg[c].fbw + h / 4];
      end
    end
    chk({nm, "_rgb"},   32'(rgb), 32'(e_rgb));
    chk({nm, "_hsync"}, 32'(hs),  32'(e_hs));
    chk({nm, "_vsync"}, 32'(vs),  32'(e_vs));
  endtask

  // Sync/blank pulse widths and periods measured from pin edges.
  task automatic measure(input bit rb);
    if (p_hs_a && !hs_a) begin
      if (!a_first_seen) chk("a_first_hs_fall", n_a, 658);
      else               chk("a_hs_period", n_a - a_fall, 800);
      a_first_seen = 1'b1;
      a_fall = n_a;
    end
    if (!p_hs_a && hs_a && a_fall >= 0) chk("a_hs_low", n_a - a_fall, 96);
    if (rb) begin
      b_hfall  = -1;
      b_vfall  = -1;
      b_vbrise = -1;
    end else begin
      if (p_hs_b && !hs_b) begin
        if (b_hfall >= 0) chk("b_hs_period", n_b - b_hfall, 80);
        b_hfall = n_b;
      end
      if (!p_hs_b && hs_b && b_hfall >= 0) chk("b_hs_low", n_b - b_hfall, 8);
      if (p_vs_b && !vs_b) begin
        if (b_vfall >= 0) chk("b_vs_period", n_b - b_vfall, 4400);
        b_vfall = n_b;
      end
      if (!p_vs_b && vs_b && b_vfall >= 0) chk("b_vs_low", n_b - b_vfall, 160);
      if (!p_vb_b && vb_b) b_vbrise = n_b;
      if (p_vb_b && !vb_b && b_vbrise >= 0) chk("b_vblank_len", n_b - b_vbrise, 560);
    end
    p_hs_a = hs_a;
    p_hs_b = hs_b;
    p_vs_b = vs_b;
    p_vb_b = vb_b;
  endtask

  task automatic tick();
    bit ra, rb, fa, fb, ta, tb2;
    ra  = rst_a;
    rb  = rst_b;
    fa  = frc_a;
    fb  = frc_b;
    ta  = tp_a;
    tb2 = tp_b;
    @(posedge clk);
    #1;
    n_a = ra ? 0 : n_a + 1;
    n_b = rb ? 0 : n_b + 1;
    check_dut(0, n_a, fa_last, ta,  addr_a, rgb_a, hs_a, vs_a, vb_a);
    check_dut(1, n_b, fb_last, tb2, addr_b, rgb_b, hs_b, vs_b, vb_b);
    fa_last = fa;
    fb_last = fb;
    measure(rb);
  endtask

  initial begin
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 160};
    cfg[1] = '{64, 4, 8, 4, 48, 2, 2, 3, 16};
    for (int i = 0; i < 19200; i++) mem[i] = 3'($urandom_range(0, 7));
    passes = 0; total = 0; n_a = 0; n_b = 0;
    fa_last = 1'b0; fb_last = 1'b0; a_first_seen = 1'b0;
    a_fall = -1; b_hfall = -1; b_vfall = -1; b_vbrise = -1;
    p_hs_a = 1'b1; p_hs_b = 1'b1; p_vs_b = 1'b1; p_vb_b = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    frc_a = 1'b0; frc_b = 1'b0;
    tp_a  = 1'b0; tp_b  = 1'b0;

    // Reset held for three cycles.
    repeat (3) tick();
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Free run: two full frames of b, the first eleven lines of a.
    // a draws from the RAM or forced white on a random choice per line;
    // b shows RAM data in frame 1 and forced white in frame 2.
    for (int i = 0; i < 9000; i++) begin
      if (n_a % 800 == 0) frc_a = ($urandom_range(0, 3) == 0);
      frc_b = (n_b >= 4400 && n_b < 8800);
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
      tp_a = (n_a >= 2400 && n_a < 4000);
`endif
      tick();
      if (n_a == 7205) chk("a_addr_h5_v9", 32'(addr_a), 321);
    end

    // Walk b to raster (30,20) and pulse reset for one cycle there.
    for (int i = 0; i < 4400; i++) begin
      if (n_b % 4400 == 20 * 80 + 30) break;
      tick();
    end
    chk("b_pre_reset_pos", n_b % 4400, 1630);
    rst_b = 1'b1;
    tick();
    chk("b_reset_addr", 32'(addr_b), 0);
    rst_b = 1'b0;
    repeat (600) tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule : tb_vga_scanout

`default_nettype wire
